// File: rtl/prefix_add_seq_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
// The optional signed-overflow output is enabled by PREFIX_ADD_SEQ_OVF_EN.
package prefix_add_seq_pkg;

    localparam int DEF_LEN_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/prefix_add_seq_if.sv
// Command, operand and result channels of prefix_add_seq, plus a state debug tap.
// out_ovf exists only when PREFIX_ADD_SEQ_OVF_EN is defined.
interface prefix_add_seq_if
    import prefix_add_seq_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
);

    // Each channel transfers on a rising clk edge where valid and ready are both 1.
    // The source holds its payload stable while valid=1 and ready=0; ready may
    // depend on the current state but never combinationally on the valid it gates.
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [LEN_W-1:0] cmd_len;

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;

    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;
    logic             out_cout;
`ifdef PREFIX_ADD_SEQ_OVF_EN
    logic             out_ovf;
`endif

    state_e           dbg_state;

    modport slave (
        input  cmd_valid, cmd_op, cmd_len,
        input  in_valid, in_a, in_b,
        input  out_ready,
        output cmd_ready, in_ready,
        output out_valid, out_data, out_last, out_cout,
`ifdef PREFIX_ADD_SEQ_OVF_EN
        output out_ovf,
`endif
        output dbg_state
    );

    modport master (
        output cmd_valid, cmd_op, cmd_len,
        output in_valid, in_a, in_b,
        output out_ready,
        input  cmd_ready, in_ready,
        input  out_valid, out_data, out_last, out_cout,
`ifdef PREFIX_ADD_SEQ_OVF_EN
        input  out_ovf,
`endif
        input  dbg_state
    );

endinterface

// File: rtl/pfx_byte_alu.sv
// Byte add/subtract slice around prefixAdd: B inversion for SUB, derived carry-out
// and, with PREFIX_ADD_SEQ_OVF_EN, signed overflow of the byte.
module pfx_byte_alu
    import prefix_add_seq_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       op,
    input  logic       cin,
    output logic [7:0] sum,
`ifdef PREFIX_ADD_SEQ_OVF_EN
    output logic       ovf,
`endif
    output logic       cout
);

    logic [7:0] b_eff;

    assign b_eff = b ^ {8{op == OP_SUB}};

    prefixAdd u_add (
        .a   (a),
        .b   (b_eff),
        .cin (cin),
        .sum (sum)
    );

    // With a7^b7 set, sum7 is the inverted carry into bit 7, which is then the carry out.
    assign cout = (a[7] & b_eff[7]) | ((a[7] ^ b_eff[7]) & ~sum[7]);

`ifdef PREFIX_ADD_SEQ_OVF_EN
    assign ovf = (a[7] == b_eff[7]) & (sum[7] != a[7]);
`endif

endmodule

// File: rtl/prefixAdd.sv
// 8-bit Kogge-Stone prefix adder with carry-in; it has no carry-out port.
// Only the group generates that feed sum bits are built.
module prefixAdd (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum
);

    logic [7:0] p;
    logic [6:0] g0;
    logic [6:0] g1;
    logic [6:2] p1;
    logic [6:0] g2;
    logic [6:4] p2;
    logic [6:0] g3;

    always_comb begin
        p  = a ^ b;
        g0 = a[6:0] & b[6:0];
        // Folding cin into bit 0 makes every g3[i] the carry into bit i+1.
        g0[0] = g0[0] | (p[0] & cin);

        g1 = g0;
        for (int i = 1; i < 7; i++) begin
            g1[i] = g0[i] | (p[i] & g0[i-1]);
        end
        for (int i = 2; i < 7; i++) begin
            p1[i] = p[i] & p[i-1];
        end

        g2 = g1;
        for (int i = 2; i < 7; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
        end
        for (int i = 4; i < 7; i++) begin
            p2[i] = p1[i] & p1[i-2];
        end

        g3 = g2;
        for (int i = 4; i < 7; i++) begin
            g3[i] = g2[i] | (p2[i] & g2[i-4]);
        end

        sum = p ^ {g3, cin};
    end

endmodule

// File: rtl/prefix_add_seq.sv
// Multi-precision add/subtract sequencer: chains carry across LSB-first byte pairs.
// PREFIX_ADD_SEQ_OVF_EN adds a signed-overflow flag on the final result byte.
module prefix_add_seq
    import prefix_add_seq_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    prefix_add_seq_if.slave  bus
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             op_q, op_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_cout_q, out_cout_d;
`ifdef PREFIX_ADD_SEQ_OVF_EN
    logic             out_ovf_q, out_ovf_d;
    logic             alu_ovf;
`endif

    logic [7:0]       alu_sum;
    logic             alu_cout;
    logic             in_fire;
    logic             is_last;

    pfx_byte_alu u_alu (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .op   (op_q),
        .cin  (carry_q),
        .sum  (alu_sum),
`ifdef PREFIX_ADD_SEQ_OVF_EN
        .ovf  (alu_ovf),
`endif
        .cout (alu_cout)
    );

    // Single output register without skid: a new byte enters only as the old one leaves.
    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.in_ready  = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign is_last       = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
`ifdef PREFIX_ADD_SEQ_OVF_EN
        out_ovf_d   = out_ovf_q;
`endif

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    cnt_d   = bus.cmd_len;
                    carry_d = (bus.cmd_op == OP_SUB);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_fire) begin
                    out_valid_d = 1'b1;
                    out_data_d  = alu_sum;
                    out_last_d  = is_last;
                    out_cout_d  = is_last & alu_cout;
`ifdef PREFIX_ADD_SEQ_OVF_EN
                    out_ovf_d   = is_last & alu_ovf;
`endif
                    carry_d     = alu_cout;
                    cnt_d       = is_last ? '0 : cnt_q - LEN_W'(1);
                    if (is_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            op_q        <= OP_ADD;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
`ifdef PREFIX_ADD_SEQ_OVF_EN
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
`ifdef PREFIX_ADD_SEQ_OVF_EN
            out_ovf_q   <= out_ovf_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_cout  = out_cout_q;
`ifdef PREFIX_ADD_SEQ_OVF_EN
    assign bus.out_ovf   = out_ovf_q;
`endif
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_prefix_add_seq.sv
// Randomised and directed bench for prefix_add_seq with a whole-number reference model.
// Define PREFIX_ADD_SEQ_OVF_EN for both RTL and bench to cover the overflow output.
module tb_prefix_add_seq;
    import prefix_add_seq_pkg::*;

    localparam int LW = 4;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;
    int bp_mode = 0;  // 0: out_ready held 1, 1: random, 2: driven by a test

    logic [10:0] exp_q[$];  // {ovf, cout, last, data}

    prefix_add_seq_if #(.LEN_W(LW)) bus ();

    prefix_add_seq #(.LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Operands are whole numbers of n bytes; result bytes come from plain arithmetic.
    function automatic logic [10:0] ref_byte(input logic op, input int n,
                                             input logic [127:0] a, input logic [127:0] b,
                                             input int i);
        logic [131:0] ua, ub, modv, r;
        logic signed [131:0] sa, sb, sr, half, m;
        logic cout, ovf, last;
        modv = 132'd1 << (8 * n);
        ua = {4'b0, a};
        ub = {4'b0, b};
        if (op) begin
            r    = ua + modv - ub;
            cout = (ua >= ub);
        end else begin
            r    = ua + ub;
            cout = r[8*n];
        end
        m    = $signed(modv);
        half = $signed(modv >> 1);
        sa = $signed(ua);
        if (sa >= half) sa = sa - m;
        sb = $signed(ub);
        if (sb >= half) sb = sb - m;
        sr   = op ? (sa - sb) : (sa + sb);
        ovf  = (sr >= half) || (sr < -half);
        last = (i == n - 1);
`ifndef PREFIX_ADD_SEQ_OVF_EN
        ovf = 1'b0;
`endif
        return {last & ovf, last & cout, last, r[8*i +: 8]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_cmd(input logic op, input int len, input logic [127:0] a,
                           input logic [127:0] b, input int n_send, input bit gaps);
        int n;
        int t;
        n = len + 1;
        bus.cmd_op    = op;
        bus.cmd_len   = LW'(len);
        bus.cmd_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.cmd_ready && t < 500);
        if (!bus.cmd_ready) begin
            errors++;
            $display("FAIL cmd_ready_timeout actual=0 required=1");
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < n_send; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_a     = a[8*i +: 8];
            bus.in_b     = b[8*i +: 8];
            bus.in_valid = 1'b1;
            exp_q.push_back(ref_byte(op, n, a, b, i));
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.in_ready && t < 500);
            if (!bus.in_ready) begin
                errors++;
                $display("FAIL in_ready_timeout actual=0 required=1");
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic stall_byte1(input logic [7:0] held_exp);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.out_valid && t < 500);
        if (!bus.out_valid) begin
            errors++;
            $display("FAIL stall_wait_timeout actual=0 required=1");
            return;
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_out_data", 32'(bus.out_data), 32'(held_exp));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 0) bus.out_ready = 1'b1;
            else if (bp_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [10:0] act;
        logic [10:0] req;
        logic        ovf_a;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
`ifdef PREFIX_ADD_SEQ_OVF_EN
                ovf_a = bus.out_ovf;
`else
                ovf_a = 1'b0;
`endif
                act = {ovf_a, bus.out_cout, bus.out_last, bus.out_data};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", act);
                end else begin
                    req = exp_q.pop_front();
                    if (act !== req) begin
                        errors++;
                        $display("FAIL result_byte actual={ovf,cout,last,data}=%0h required=%0h",
                                 act, req);
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] a, b, mask;
        logic [10:0]  e1;
        int           len;
        int           t;
        logic         op;

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_cout", 32'(bus.out_cout), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
`ifdef PREFIX_ADD_SEQ_OVF_EN
        check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases: carry out of one byte, carry chained, borrow, overflow.
        run_cmd(OP_ADD, 0, 128'hFF, 128'h01, 1, 0);
        run_cmd(OP_ADD, 1, 128'h00FF, 128'h0001, 2, 0);
        run_cmd(OP_SUB, 1, 128'h0100, 128'h0001, 2, 0);
        run_cmd(OP_SUB, 0, 128'h00, 128'h01, 1, 0);
        run_cmd(OP_ADD, 0, 128'h7F, 128'h01, 1, 0);
        run_cmd(OP_ADD, 0, 128'hFF, 128'h01, 1, 0);
        run_cmd(OP_SUB, 0, 128'h80, 128'h01, 1, 0);

        // Backpressure on the second byte of a four-byte stream.
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bp_mode = 2;
        bus.out_ready = 1'b1;
        a = 128'h89AB_CDEF;
        b = 128'h0102_0304;
        e1 = ref_byte(OP_ADD, 4, a, b, 1);
        fork
            run_cmd(OP_ADD, 3, a, b, 4, 0);
            stall_byte1(e1[7:0]);
        join

        // Random commands with random gaps and random sink backpressure.
        bp_mode = 1;
        for (int k = 0; k < 40; k++) begin
            op  = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 15);
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            mask = (len == 15) ? '1 : ((128'd1 << (8 * (len + 1))) - 128'd1);
            run_cmd(op, len, a & mask, b & mask, len + 1, 1);
        end

        // Reset in the middle of a four-byte command.
        bp_mode = 0;
        run_cmd(OP_ADD, 3, 128'hFFFF_FFFF, 128'h0000_0001, 2, 0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_cmd(OP_ADD, 0, 128'h10, 128'h20, 1, 0);

        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("final_out_valid", 32'(bus.out_valid), 32'd0);
        check("final_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prefix_add_seq.md
Name: prefix_add_seq

Overview:
- Multi-precision add/subtract sequencer built around the team's 8-bit prefix adder (prefixAdd).
- Accepts a command (op, length), streams operand byte pairs LSB-first, and chains the carry between bytes through a register.
- Emits one result byte per accepted input byte, with the final carry/borrow on the last byte.
- Sits between a byte-wide operand source and a result sink.

Parameters:
- LEN_W, 4, width of command length field; a command covers len+1 bytes (1..2^LEN_W).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  sequencer idle and able to accept a command.
- cmd_op  input  1  0 = ADD, 1 = SUB (A − B).
- cmd_len  input  LEN_W  number of bytes minus 1.
- in_valid  input  1  operand byte pair offered.
- in_ready  output  1  operand pair can be accepted.
- in_a  input  8  operand A byte, LSB byte first.
- in_b  input  8  operand B byte.
- out_valid  output  1  result byte held.
- out_ready  input  1  sink accepts result.
- out_data  output  8  result byte.
- out_last  output  1  final byte of the command.
- out_cout  output  1  carry out of the final byte (SUB: 1 = no borrow); valid only with out_last, else 0.

Behaviour:
- States: IDLE and RUN.
- Reset: state IDLE; cmd_ready=1 after reset; in_ready=0; out_valid/out_data/out_last/out_cout=0; internal carry and count=0.
- IDLE:
  - cmd_ready=1 and in_ready=0; in_valid is ignored.
  - On cmd_valid&cmd_ready: latch op; cnt←cmd_len; carry←op (SUB seeds cin=1); go to RUN.
- RUN:
  - cmd_ready=0.
  - in_ready = !out_valid | out_ready (single output register, no skid).
- On in_valid&in_ready:
  - Adder operands: a=in_a, b=in_b ^ {8{op}}, cin=carry.
  - Register sum into out_data; out_valid←1.
  - carry←cout, where cout = (a7&b7) | ((a7^b7)&~S7); the adder has no carry-out port, so cout is derived this way.
  - out_last←(cnt==0); out_cout←cout if last, else 0.
  - cnt←cnt−1.
  - If last: return to IDLE.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 byte/cycle when out_ready=1.
- out_valid&!out_ready: out_data, out_last and out_cout held stable; in_ready=0.
- Output drain: on out_ready with no new input, out_valid←0.
- A new command is accepted in the cycle after the last input handshake, even if the last result byte is still unconsumed; its first input waits on in_ready.
- cmd_len=0: single-byte operation; out_last=1 on that byte.
- cnt counts down only; no wrap, since the RUN exit occurs at 0.
- rst mid-operation: abort immediately; any pending output is dropped (out_valid=0); return to IDLE.

Optional Feature:
- Macro PREFIX_ADD_SEQ_OVF_EN.
- When defined: extra output out_ovf (1 bit) = signed overflow of the final byte = (a7==b7) & (S7!=a7), using the post-inversion b. Valid with out_last, else 0; reset 0.
- When undefined: port absent; no overflow logic.

Decomposition:
- Package prefix_add_seq_pkg:
  - op encoding constants OP_ADD=1'b0, OP_SUB=1'b1.
  - state enum {ST_IDLE, ST_RUN}.
  - default LEN_W.
- Sub-module pfx_byte_alu (combinational): instantiates prefixAdd; applies the B inversion; produces sum, cout and (under the macro) ovf.
- The sequencer holds only FSM, counter, carry and output register.

Test Plan:
- ADD, len=0, A=0xFF, B=0x01 -> out_data=0x00, out_last=1, out_cout=1.
- ADD, len=1, bytes (0xFF,0x01),(0x00,0x00) -> 0x00 then 0x01; out_cout=0 on last; out_last only on second byte.
- SUB, len=1, A=0x0100, B=0x0001 (bytes (0x00,0x01),(0x01,0x00)) -> 0xFF then 0x00; out_cout=1 (no borrow). SUB len=0, 0x00−0x01 -> 0xFF, out_cout=0.
- Backpressure: len=3 stream with out_ready low 3 cycles on byte 1 -> in_ready=0 throughout the stall, out_data held, four results in order, no loss or duplication.
- rst asserted after 2 of 4 bytes -> next cycle out_valid=0, cmd_ready=1; a fresh ADD len=0 (0x10+0x20) then gives 0x30 with carry-in 0.
- With PREFIX_ADD_SEQ_OVF_EN: ADD len=0, 0x7F+0x01 -> 0x80, out_ovf=1, out_cout=0; 0xFF+0x01 -> out_ovf=0.
